// File: rtl/uart_regif_pkg.sv
// rtl/uart_regif_pkg.sv - register offsets, bit positions and strobe FSM type for uart_apb_regif
`timescale 1ns/1ps
package uart_regif_pkg;

    localparam logic [4:0] OFS_TXDATA   = 5'h00;
    localparam logic [4:0] OFS_RXDATA   = 5'h04;
    localparam logic [4:0] OFS_CTRL1    = 5'h08;
    localparam logic [4:0] OFS_CTRL2    = 5'h0C;
    localparam logic [4:0] OFS_STATUS   = 5'h10;
    localparam logic [4:0] OFS_CTRL3    = 5'h14;
    localparam logic [4:0] OFS_IRQ_EN   = 5'h18;
    localparam logic [4:0] OFS_IRQ_PEND = 5'h1C;

    // Word index of each register; PADDR[1:0] never participates in decode
    localparam logic [2:0] IDX_TXDATA   = OFS_TXDATA[4:2];
    localparam logic [2:0] IDX_RXDATA   = OFS_RXDATA[4:2];
    localparam logic [2:0] IDX_CTRL1    = OFS_CTRL1[4:2];
    localparam logic [2:0] IDX_CTRL2    = OFS_CTRL2[4:2];
    localparam logic [2:0] IDX_STATUS   = OFS_STATUS[4:2];
    localparam logic [2:0] IDX_CTRL3    = OFS_CTRL3[4:2];
    localparam logic [2:0] IDX_IRQ_EN   = OFS_IRQ_EN[4:2];
    localparam logic [2:0] IDX_IRQ_PEND = OFS_IRQ_PEND[4:2];

    localparam int unsigned STATUS_TXRDY       = 0;
    localparam int unsigned STATUS_RXRDY       = 1;
    localparam int unsigned STATUS_PARITY_ERR  = 2;
    localparam int unsigned STATUS_OVERFLOW    = 3;
    localparam int unsigned STATUS_FRAMING_ERR = 4;

    localparam int unsigned CTRL2_BIT8       = 0;
    localparam int unsigned CTRL2_PARITY_EN  = 1;
    localparam int unsigned CTRL2_ODD_N_EVEN = 2;
    localparam int unsigned CTRL2_BAUD_LSB   = 3;

    localparam int unsigned IRQ_RX_PEND  = 0;
    localparam int unsigned IRQ_TX_PEND  = 1;
    localparam int unsigned IRQ_ERR_PEND = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } strobe_state_t;

endpackage

// File: rtl/uart_regif_irq.sv
// rtl/uart_regif_irq.sv - status edge detection, W1C pending bits and level IRQ (built under UART_REGIF_IRQ_EN)
`timescale 1ns/1ps
module uart_regif_irq
    import uart_regif_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       PARITY_ERR,
    input  logic       OVERFLOW,
    input  logic       FRAMING_ERR,
    input  logic [2:0] irq_en,
    input  logic       w1c_valid,
    input  logic [2:0] w1c_data,
    output logic [2:0] irq_pend,
    output logic       IRQ
);

    logic [4:0] status_now;
    logic [4:0] status_q;
    logic [4:0] rise;
    logic [2:0] set_bits;
    logic [2:0] clr_bits;

    always_comb begin
        status_now                     = '0;
        status_now[STATUS_TXRDY]       = TXRDY;
        status_now[STATUS_RXRDY]       = RXRDY;
        status_now[STATUS_PARITY_ERR]  = PARITY_ERR;
        status_now[STATUS_OVERFLOW]    = OVERFLOW;
        status_now[STATUS_FRAMING_ERR] = FRAMING_ERR;
    end

    assign rise = status_now & ~status_q;

    always_comb begin
        set_bits               = '0;
        set_bits[IRQ_RX_PEND]  = rise[STATUS_RXRDY];
        set_bits[IRQ_TX_PEND]  = rise[STATUS_TXRDY];
        set_bits[IRQ_ERR_PEND] = rise[STATUS_PARITY_ERR] | rise[STATUS_OVERFLOW]
                               | rise[STATUS_FRAMING_ERR];
    end

    assign clr_bits = w1c_valid ? w1c_data : 3'b000;

    // A new event in the same cycle as its W1C keeps the bit pending
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            status_q <= '0;
            irq_pend <= '0;
            IRQ      <= 1'b0;
        end else begin
            status_q <= status_now;
            irq_pend <= (irq_pend & ~clr_bits) | set_bits;
            IRQ      <= |(irq_pend & irq_en);
        end
    end

endmodule

// File: rtl/uart_apb_regif.sv
// rtl/uart_apb_regif.sv - APB3 register front-end for the UART core; UART_REGIF_IRQ_EN adds the interrupt block
`timescale 1ns/1ps
module uart_apb_regif
    import uart_regif_pkg::*;
#(
    parameter logic [12:0] BAUD_VAL_RST   = 13'd1,
    parameter logic        BIT8_RST       = 1'b1,
    parameter logic        PARITY_EN_RST  = 1'b0,
    parameter logic        ODD_N_EVEN_RST = 1'b0
)
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [7:0]  PWDATA,
    output logic [7:0]  PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        CSN,
    output logic        WEN,
    output logic        OEN,
    output logic [7:0]  DATA_IN,
    input  logic [7:0]  DATA_OUT,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic        PARITY_ERR,
    input  logic        OVERFLOW,
    input  logic        FRAMING_ERR,
    output logic [12:0] BAUD_VAL,
    output logic [2:0]  BAUD_VAL_FRACTION,
    output logic        BIT8,
    output logic        PARITY_EN,
    output logic        ODD_N_EVEN,
    output logic        IRQ
);

    logic          setup;
    logic          access;
    logic [2:0]    idx;
    logic          addr_err;
    logic          strobe_req;
    logic          wr_ok;
    logic          unused_ok;
    strobe_state_t state;
    logic [7:0]    status_vec;
    logic [7:0]    ctrl2_vec;

    assign PREADY    = 1'b1;
    assign setup     = PSEL & ~PENABLE;
    assign access    = PSEL & PENABLE;
    assign idx       = PADDR[4:2];
    assign unused_ok = &{1'b0, PADDR[1:0]};

    always_comb begin
        addr_err = 1'b0;
        if (idx == IDX_TXDATA)
            addr_err = ~PWRITE;
        else if (idx == IDX_RXDATA || idx == IDX_STATUS)
            addr_err = PWRITE;
`ifndef UART_REGIF_IRQ_EN
        else if (idx == IDX_IRQ_EN || idx == IDX_IRQ_PEND)
            addr_err = 1'b1;
`endif
    end

    assign strobe_req = setup & ((PWRITE & (idx == IDX_TXDATA)) | (~PWRITE & (idx == IDX_RXDATA)));
    assign wr_ok      = access & PWRITE & ~addr_err;

    // Strobes are loaded on the setup edge so they cover exactly the access cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            CSN     <= 1'b1;
            WEN     <= 1'b1;
            OEN     <= 1'b1;
            DATA_IN <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PSLVERR <= setup & addr_err;
            case (state)
                ST_IDLE: begin
                    if (strobe_req) begin
                        state <= ST_STROBE;
                        CSN   <= 1'b0;
                        WEN   <= ~PWRITE;
                        OEN   <= PWRITE;
                        if (PWRITE)
                            DATA_IN <= PWDATA;
                    end
                end
                ST_STROBE: begin
                    state <= ST_IDLE;
                    CSN   <= 1'b1;
                    WEN   <= 1'b1;
                    OEN   <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BAUD_VAL          <= BAUD_VAL_RST;
            BAUD_VAL_FRACTION <= '0;
            BIT8              <= BIT8_RST;
            PARITY_EN         <= PARITY_EN_RST;
            ODD_N_EVEN        <= ODD_N_EVEN_RST;
        end else if (wr_ok) begin
            case (idx)
                IDX_CTRL1: BAUD_VAL[7:0] <= PWDATA;
                IDX_CTRL2: begin
                    BIT8           <= PWDATA[CTRL2_BIT8];
                    PARITY_EN      <= PWDATA[CTRL2_PARITY_EN];
                    ODD_N_EVEN     <= PWDATA[CTRL2_ODD_N_EVEN];
                    BAUD_VAL[12:8] <= PWDATA[CTRL2_BAUD_LSB +: 5];
                end
                IDX_CTRL3: BAUD_VAL_FRACTION <= PWDATA[2:0];
                default: ;
            endcase
        end
    end

`ifdef UART_REGIF_IRQ_EN
    logic [7:0] irq_en;
    logic [2:0] irq_pend;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            irq_en <= '0;
        else if (wr_ok && idx == IDX_IRQ_EN)
            irq_en <= PWDATA;
    end

    uart_regif_irq u_irq (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .TXRDY       (TXRDY),
        .RXRDY       (RXRDY),
        .PARITY_ERR  (PARITY_ERR),
        .OVERFLOW    (OVERFLOW),
        .FRAMING_ERR (FRAMING_ERR),
        .irq_en      (irq_en[2:0]),
        .w1c_valid   (wr_ok && idx == IDX_IRQ_PEND),
        .w1c_data    (PWDATA[2:0]),
        .irq_pend    (irq_pend),
        .IRQ         (IRQ)
    );
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        status_vec                     = '0;
        status_vec[STATUS_TXRDY]       = TXRDY;
        status_vec[STATUS_RXRDY]       = RXRDY;
        status_vec[STATUS_PARITY_ERR]  = PARITY_ERR;
        status_vec[STATUS_OVERFLOW]    = OVERFLOW;
        status_vec[STATUS_FRAMING_ERR] = FRAMING_ERR;

        ctrl2_vec                          = '0;
        ctrl2_vec[CTRL2_BIT8]              = BIT8;
        ctrl2_vec[CTRL2_PARITY_EN]         = PARITY_EN;
        ctrl2_vec[CTRL2_ODD_N_EVEN]        = ODD_N_EVEN;
        ctrl2_vec[CTRL2_BAUD_LSB +: 5]     = BAUD_VAL[12:8];
    end

    // RXDATA returns the core byte live, before the core's own clearing edge
    always_comb begin
        PRDATA = '0;
        if (access && !addr_err) begin
            case (idx)
                IDX_RXDATA:   PRDATA = DATA_OUT;
                IDX_CTRL1:    PRDATA = BAUD_VAL[7:0];
                IDX_CTRL2:    PRDATA = ctrl2_vec;
                IDX_STATUS:   PRDATA = status_vec;
                IDX_CTRL3:    PRDATA = {5'b0, BAUD_VAL_FRACTION};
`ifdef UART_REGIF_IRQ_EN
                IDX_IRQ_EN:   PRDATA = irq_en;
                IDX_IRQ_PEND: PRDATA = {5'b0, irq_pend};
`endif
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_regif.sv
// tb/tb_uart_apb_regif.sv - table, directed and randomized checks of uart_apb_regif against a register-level model
`timescale 1ns/1ps
module tb_uart_apb_regif;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [7:0]  PWDATA = '0;
    logic [7:0]  PRDATA;
    logic        PREADY, PSLVERR, CSN, WEN, OEN;
    logic [7:0]  DATA_IN;
    logic [7:0]  DATA_OUT = '0;
    logic [4:0]  st = '0;
    logic [12:0] BAUD_VAL;
    logic [2:0]  BAUD_VAL_FRACTION;
    logic        BIT8, PARITY_EN, ODD_N_EVEN, IRQ;

    uart_apb_regif dut (
        .CLK(CLK), .RESET_N(RESET_N), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .TXRDY(st[0]), .RXRDY(st[1]), .PARITY_ERR(st[2]), .OVERFLOW(st[3]), .FRAMING_ERR(st[4]),
        .BAUD_VAL(BAUD_VAL), .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION), .BIT8(BIT8),
        .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] m_baud;
    logic        m_bit8, m_par, m_odd;
    logic [2:0]  m_frac;
    logic [7:0]  m_irq_en;
    logic [2:0]  m_pend;
    logic [7:0]  m_din;

    logic [7:0]  s_rd, s_din;
    logic        s_err, s_csn, s_wen, s_oen;
    logic [2:0]  a_strb;

    typedef struct {
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        bit         err;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_baud = 13'd1; m_bit8 = 1'b1; m_par = 1'b0; m_odd = 1'b0; m_frac = '0;
        m_irq_en = '0; m_pend = '0; m_din = '0;
    endtask

    function automatic bit exp_err(input bit w, input logic [4:0] a);
        case (a[4:2])
            3'd0:       return !w;
            3'd1, 3'd4: return w;
`ifdef UART_REGIF_IRQ_EN
            3'd6, 3'd7: return 1'b0;
`else
            3'd6, 3'd7: return 1'b1;
`endif
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_read(input logic [4:0] a);
        case (a[4:2])
            3'd1:    return DATA_OUT;
            3'd2:    return m_baud[7:0];
            3'd3:    return {m_baud[12:8], m_odd, m_par, m_bit8};
            3'd4:    return {3'b0, st};
            3'd5:    return {5'b0, m_frac};
            3'd6:    return m_irq_en;
            3'd7:    return {5'b0, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_irq();
`ifdef UART_REGIF_IRQ_EN
        return |(m_pend & m_irq_en[2:0]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apb(input bit w, input logic [4:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        #2;
        s_rd = PRDATA; s_err = PSLVERR; s_csn = CSN; s_wen = WEN; s_oen = OEN; s_din = DATA_IN;
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        #2;
        a_strb = {CSN, WEN, OEN};
    endtask

    task automatic check_cfg();
        @(posedge CLK); #3;
        chk("baud_val", BAUD_VAL, m_baud);
        chk("baud_frac", BAUD_VAL_FRACTION, m_frac);
        chk("cfg_bits", {BIT8, PARITY_EN, ODD_N_EVEN}, {m_bit8, m_par, m_odd});
        chk("irq", IRQ, exp_irq());
    endtask

    task automatic apb_check(input bit w, input logic [4:0] a, input logic [7:0] d);
        bit e_err, strobe;
        logic [7:0] e_rd;
        e_err  = exp_err(w, a);
        e_rd   = exp_read(a);
        strobe = !e_err && ((w && a[4:2] == 3'd0) || (!w && a[4:2] == 3'd1));
        apb(w, a, d);
        chk("pslverr", s_err, e_err);
        if (!w && !e_err) chk("prdata", s_rd, e_rd);
        chk("csn_access", s_csn, !strobe);
        chk("wen_access", s_wen, !(strobe && w));
        chk("oen_access", s_oen, !(strobe && !w));
        if (strobe && w) m_din = d;
        chk("data_in", s_din, m_din);
        chk("strobe_release", a_strb, 3'b111);
        if (w && !e_err) begin
            case (a[4:2])
                3'd2: m_baud[7:0] = d;
                3'd3: begin m_bit8 = d[0]; m_par = d[1]; m_odd = d[2]; m_baud[12:8] = d[7:3]; end
                3'd5: m_frac = d[2:0];
                3'd6: m_irq_en = d;
                3'd7: m_pend = m_pend & ~d[2:0];
                default: ;
            endcase
        end
        check_cfg();
    endtask

    task automatic set_status(input logic [4:0] nv);
        @(posedge CLK); #1;
        if (nv[1] && !st[1]) m_pend[0] = 1'b1;
        if (nv[0] && !st[0]) m_pend[1] = 1'b1;
        if (|(nv[4:2] & ~st[4:2])) m_pend[2] = 1'b1;
        st = nv;
        @(posedge CLK); #1;
    endtask

    initial begin
        tbl[0]  = '{0, 5'h08, 8'h00, 8'h01, 0};
        tbl[1]  = '{0, 5'h0C, 8'h00, 8'h01, 0};
        tbl[2]  = '{1, 5'h00, 8'h55, 8'h00, 0};
        tbl[3]  = '{0, 5'h04, 8'h00, 8'hA3, 0};
        tbl[4]  = '{0, 5'h10, 8'h00, 8'h02, 0};
        tbl[5]  = '{0, 5'h11, 8'h00, 8'h02, 0};
        tbl[6]  = '{1, 5'h0C, 8'hFF, 8'h00, 0};
        tbl[7]  = '{1, 5'h08, 8'h34, 8'h00, 0};
        tbl[8]  = '{1, 5'h10, 8'hAA, 8'h00, 1};
        tbl[9]  = '{0, 5'h14, 8'h00, 8'h00, 0};
        tbl[10] = '{0, 5'h00, 8'h00, 8'h00, 1};
        tbl[11] = '{0, 5'h0C, 8'h00, 8'hFF, 0};
        tbl[12] = '{0, 5'h09, 8'h00, 8'h34, 0};
`ifdef UART_REGIF_IRQ_EN
        tbl[13] = '{0, 5'h18, 8'h00, 8'h00, 0};
`else
        tbl[13] = '{0, 5'h18, 8'h00, 8'h00, 1};
`endif
        tbl[14] = '{1, 5'h04, 8'h12, 8'h00, 1};
        tbl[15] = '{1, 5'h14, 8'h05, 8'h00, 0};
        tbl[16] = '{0, 5'h14, 8'h00, 8'h05, 0};

        model_reset();
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        #2;
        chk("rst_strobes", {CSN, WEN, OEN}, 3'b111);
        chk("rst_data_in", DATA_IN, 8'h00);
        chk("rst_irq", IRQ, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_baud", BAUD_VAL, 13'd1);
        chk("rst_cfg", {BIT8, PARITY_EN, ODD_N_EVEN, BAUD_VAL_FRACTION}, 6'b100_000);
        chk("pready", PREADY, 1'b1);

        DATA_OUT = 8'hA3;
        set_status(5'b00010);
        check_cfg();
        for (int i = 0; i < 17; i++) begin
            apb_check(tbl[i].w, tbl[i].a, tbl[i].d);
            chk("tbl_err", s_err, tbl[i].err);
            if (!tbl[i].w && !tbl[i].err) chk("tbl_rdata", s_rd, tbl[i].rd);
        end
        chk("baud_1f34", BAUD_VAL, 13'h1F34);
        chk("ctrl2_bits", {BIT8, PARITY_EN, ODD_N_EVEN}, 3'b111);

`ifdef UART_REGIF_IRQ_EN
        apb_check(1'b1, 5'h18, 8'h01);
        set_status(5'b00000);
        check_cfg();
        apb_check(1'b1, 5'h1C, 8'h07);
        chk("irq_cleared", IRQ, 1'b0);
        set_status(5'b00010);
        chk("irq_latency_1", IRQ, 1'b0);
        check_cfg();
        chk("irq_latency_2", IRQ, 1'b1);
        set_status(5'b00000);
        check_cfg();
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h1C; PWDATA = 8'h01;
        @(posedge CLK); #1;
        PENABLE = 1'b1; st = 5'b00010;
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        m_pend[0] = 1'b1;
        check_cfg();
        apb_check(1'b0, 5'h1C, 8'h00);
        chk("rx_pend_wins", s_rd[0], 1'b1);
`else
        for (int i = 0; i < 4; i++) begin
            set_status((i % 2 == 0) ? 5'b11111 : 5'b00000);
            check_cfg();
            chk("irq_tied_low", IRQ, 1'b0);
        end
        apb_check(1'b1, 5'h1C, 8'h07);
`endif

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_status(5'($urandom_range(0, 31)));
                check_cfg();
            end else begin
                DATA_OUT = 8'($urandom);
                apb_check(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
            end
        end

        set_status(5'b00000);
        check_cfg();
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 8'h77;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        #1;
        chk("pre_reset_csn", CSN, 1'b0);
        #1 RESET_N = 1'b0;
        #1;
        chk("async_rst_strobes", {CSN, WEN, OEN}, 3'b111);
        chk("async_rst_data_in", DATA_IN, 8'h00);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        model_reset();
        check_cfg();
        apb_check(1'b0, 5'h08, 8'h00);
        chk("post_rst_ctrl1", s_rd, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_apb_regif.md
# uart_apb_regif

APB3 slave register front-end that sits directly upstream of the UART core. Decodes APB transfers into the core's active-low CSN/WEN/OEN strobes and DATA_IN, holds the static line configuration (BAUD_VAL, BAUD_VAL_FRACTION, BIT8, PARITY_EN, ODD_N_EVEN), returns DATA_OUT and status flags on PRDATA, and generates a level interrupt from status events. All transfers complete with zero wait states.

## Interface
- BAUD_VAL_RST, 13'd1, reset value of BAUD_VAL
- BIT8_RST, 1, reset value of BIT8
- PARITY_EN_RST, 0, reset value of PARITY_EN
- ODD_N_EVEN_RST, 0, reset value of ODD_N_EVEN
- CLK  in  1  system clock, same clock as the UART core
- RESET_N  in  1  asynchronous, active-low reset
- PSEL, PENABLE, PWRITE  in  1  APB3 control
- PADDR  in  5  byte address; [4:2] selects register, [1:0] ignored
- PWDATA  in  8  write data
- PRDATA  out  8  read data, combinational, valid in access cycle
- PREADY  out  1  constant 1
- PSLVERR  out  1  access-cycle error, unmapped offset or write to read-only
- CSN, WEN, OEN  out  1  registered strobes to core, active low
- DATA_IN  out  8  registered TX byte to core
- DATA_OUT  in  8  RX byte from core
- TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR  in  1  core status
- BAUD_VAL  out  13; BAUD_VAL_FRACTION  out  3; BIT8, PARITY_EN, ODD_N_EVEN  out  1  configuration
- IRQ  out  1  registered level interrupt

## Operation
- Register map:
  - 0x00 TXDATA (W).
  - 0x04 RXDATA (R).
  - 0x08 CTRL1 (RW) = BAUD_VAL[7:0].
  - 0x0C CTRL2 (RW): [0] BIT8, [1] PARITY_EN, [2] ODD_N_EVEN, [7:3] BAUD_VAL[12:8].
  - 0x10 STATUS (R): [0] TXRDY, [1] RXRDY, [2] PARITY_ERR, [3] OVERFLOW, [4] FRAMING_ERR, [7:5] 0.
  - 0x14 CTRL3 (RW): [2:0] BAUD_VAL_FRACTION.
  - 0x18 IRQ_EN (RW).
  - 0x1C IRQ_PEND (R/W1C).
- Strobe FSM, states IDLE and STROBE:
  - IDLE -> STROBE on setup phase (PSEL=1, PENABLE=0) that targets TXDATA-write or RXDATA-read. The next edge loads CSN=0 plus WEN=0 (write) or OEN=0 (read); DATA_IN<=PWDATA on write.
  - STROBE -> IDLE unconditionally. Strobes return to 1 on that edge.
  - Strobes are low for exactly the APB access cycle, one CLK.
- Reads of STATUS, CTRL, and IRQ registers never assert CSN, so they have no side effect on the core.
- PRDATA:
  - During a RXDATA access it is DATA_OUT, sampled by the master before the core's clearing edge.
  - During other accesses it is the addressed register value; 0 outside access cycles.
- Config writes update on the access-cycle edge.
- PSLVERR=1 in the access cycle for:
  - writes to 0x04 or 0x10;
  - reads of 0x00;
  - any access to an unmapped offset.
- An errored access generates no strobe and no register update.
- IRQ_PEND bits:
  - [0] RX_PEND, set on RXRDY 0->1.
  - [1] TX_PEND, set on TXRDY 0->1.
  - [2] ERR_PEND, set on a 0->1 of any of PARITY_ERR, OVERFLOW or FRAMING_ERR.
- Edges are detected against a one-cycle delayed copy of each input.
- Writing 1 clears a bit. If a set and a clear land in the same cycle, the set wins.
- IRQ <= |(IRQ_PEND & IRQ_EN[2:0]).

## Timing
- Reset values:
  - CSN=WEN=OEN=1, DATA_IN=0, IRQ=0, PSLVERR=0, FSM=IDLE.
  - Config outputs take their *_RST parameters; BAUD_VAL_FRACTION=0.
  - IRQ_EN=0, IRQ_PEND=0, edge-detect copies=0.
- Reset asserted mid-transfer forces strobes high immediately (asynchronous); the in-flight transfer is discarded.
- Back-to-back transfers: APB guarantees a setup cycle between accesses, so strobes are never asserted in consecutive cycles.
- Status event to IRQ latency: 2 CLK (edge capture plus pending register, then IRQ register).
- Config write: the new value appears on the output port in the cycle after the access edge.

## Configuration
- UART_REGIF_IRQ_EN defined: IRQ_EN, IRQ_PEND, edge detectors and the IRQ register are present as described.
- UART_REGIF_IRQ_EN undefined:
  - those registers and detectors are not built;
  - IRQ is tied 0;
  - offsets 0x18 and 0x1C are unmapped and raise PSLVERR.

## Structure
- Package uart_regif_pkg holds:
  - register offset constants;
  - STATUS, CTRL2 and IRQ bit-position constants;
  - the strobe FSM state typedef.
- Sub-module uart_regif_irq: edge detection, W1C pending register and IRQ output. It is instantiated only under UART_REGIF_IRQ_EN.

## Test plan
- Reset, then read CTRL1/CTRL2 -> 0x01 / 0x01; BAUD_VAL=1; strobes high; IRQ=0.
- Write 0x55 to 0x00 -> CSN=WEN=0 for exactly the access cycle with DATA_IN=0x55; OEN stays 1.
- Core presents DATA_OUT=0xA3 and RXRDY=1; read 0x04 -> PRDATA=0xA3, CSN=OEN=0 for one cycle; reading 0x10 twice gives no strobes.
- Write CTRL2=0xFF, CTRL1=0x34 -> BAUD_VAL=0x1F34, BIT8=PARITY_EN=ODD_N_EVEN=1. Write to 0x10 and read of 0x14 -> PSLVERR=1 only for the 0x10 write, no state change.
- With macro: IRQ_EN=0x01, pulse RXRDY 0->1 -> IRQ=1 two cycles later. Write 0x01 to 0x1C in the same cycle as a new RXRDY edge -> RX_PEND stays 1.
- Without macro: access 0x18 -> PSLVERR=1; IRQ stays 0 under all status activity.
